cache_nway_wb: RTL and testbench

//  Parametrised N-way set-associative write-back, write-allocate cache with integrated control FSM.

---
 rtl/cache_nway_wb.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_cache_nway_wb.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_nway_wb.sv
// cache_nway_wb: N-way set-associative write-back / write-allocate line cache.
// Tree pseudo-LRU replacement with invalid-way-first victim choice, a single
// control FSM (IDLE -> CHECK -> [WB] -> FILL -> CHECK) and saturating
// hit/miss/writeback counters.
//
// Handshake: the CPU holds mem_read/mem_write (with address/data/enables)
// until the single-cycle mem_resp pulse; the cache holds pmem_read/pmem_write
// (with address/data) until the single-cycle pmem_resp pulse. A request is
// accepted only in IDLE; a pmem_resp outside WB/FILL is ignored.
module cache_nway_wb #(
  parameter int S_OFFSET = 5,
  parameter int S_INDEX  = 3,
  parameter int NUM_WAYS = 4,
  parameter int CNT_W    = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mem_read,
  input  logic                          mem_write,
  input  logic [31:0]                   mem_address,
  input  logic [8*(2**S_OFFSET)-1:0]    mem_wdata256,
  input  logic [(2**S_OFFSET)-1:0]      mem_byte_enable256,
  output logic [8*(2**S_OFFSET)-1:0]    mem_rdata256,
  output logic                          mem_resp,
  output logic                          pmem_read,
  output logic                          pmem_write,
  output logic [31:0]                   pmem_address,
  output logic [8*(2**S_OFFSET)-1:0]    pmem_wdata,
  input  logic [8*(2**S_OFFSET)-1:0]    pmem_rdata,
  input  logic                          pmem_resp,
  output logic [CNT_W-1:0]              hit_count,
  output logic [CNT_W-1:0]              miss_count,
  output logic [CNT_W-1:0]              wb_count,
  output logic [1:0]                    state_dbg
);

  localparam int LINE_W = 8 * (2**S_OFFSET);
  localparam int BE_W   = 2**S_OFFSET;
  localparam int SETS   = 2**S_INDEX;
  localparam int LA_W   = 32 - S_OFFSET;
  localparam int TAG_W  = 32 - S_OFFSET - S_INDEX;
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int NODES  = NUM_WAYS - 1;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WB, S_FILL} state_t;

  state_t               state_q, state_d;
  logic [LA_W-1:0]      addr_q, addr_d;
  logic [LINE_W-1:0]    wdata_q, wdata_d;
  logic [BE_W-1:0]      be_q, be_d;
  logic                 write_q, write_d;
  logic                 miss_seen_q, miss_seen_d;
  logic [WAY_W-1:0]     victim_q, victim_d;
  logic [CNT_W-1:0]     hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]     miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0]     wb_cnt_q, wb_cnt_d;

  // Line storage (not reset) and per-set metadata (reset).
  logic [LINE_W-1:0]    data_q  [SETS][NUM_WAYS];
  logic [TAG_W-1:0]     tag_q   [SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0]  valid_q [SETS];
  logic [NUM_WAYS-1:0]  dirty_q [SETS];
  logic [NODES-1:0]     plru_q  [SETS];

  logic [S_INDEX-1:0]   idx;
  logic [TAG_W-1:0]     tag;
  logic [NUM_WAYS-1:0]  cur_valid, cur_dirty;
  logic [NODES-1:0]     cur_plru;
  logic [NUM_WAYS-1:0]  valid_set_d, dirty_set_d;
  logic [NODES-1:0]     plru_set_d;

  logic                 hit;
  logic [WAY_W-1:0]     hit_way;
  logic [LINE_W-1:0]    hit_line, merged_line;
  logic                 inv_found;
  logic [WAY_W-1:0]     inv_way, plru_way, victim_sel;
  logic                 line_we, tag_we;
  logic [WAY_W-1:0]     line_way;
  logic [LINE_W-1:0]    line_d;

  // Byte offset bits select nothing inside a whole-line interface.
  logic                 addr_lo_unused;
  assign addr_lo_unused = ^mem_address[S_OFFSET-1:0];

  assign idx       = addr_q[S_INDEX-1:0];
  assign tag       = addr_q[LA_W-1 -: TAG_W];
  assign cur_valid = valid_q[idx];
  assign cur_dirty = dirty_q[idx];
  assign cur_plru  = plru_q[idx];

  assign hit_count    = hit_cnt_q;
  assign miss_count   = miss_cnt_q;
  assign wb_count     = wb_cnt_q;
  assign state_dbg    = state_q;
  assign hit_line     = data_q[idx][hit_way];
  assign mem_rdata256 = hit_line;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Make every node on the path to way w point at the opposite subtree.
  function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] p,
                                                  input logic [WAY_W-1:0] w);
    logic [NODES-1:0] r;
    logic [WAY_W-1:0] sh;
    logic             dir;
    int               node;
    r    = p;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      sh  = w >> (WAY_W - 1 - l);
      dir = sh[0];
      r   = r & ~(NODES'(1) << node);
      if (!dir) r = r | (NODES'(1) << node);
      node = 2 * node + 1 + int'(dir);
    end
    return r;
  endfunction

  // Tag compare across the ways of the addressed set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (cur_valid[w] && (tag_q[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim: lowest invalid way, else follow the PLRU tree from the root.
  always_comb begin
    int   node;
    logic node_bit;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!cur_valid[w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    node     = 0;
    node_bit = 1'b0;
    for (int l = 0; l < WAY_W; l++) begin
      node_bit = |(cur_plru & (NODES'(1) << node));
      node     = 2 * node + 1 + int'(node_bit);
    end
    plru_way   = WAY_W'(node - NODES);
    victim_sel = inv_found ? inv_way : plru_way;
  end

  // Write-hit merge of enabled CPU bytes over the stored line.
  always_comb begin
    merged_line = hit_line;
    for (int b = 0; b < BE_W; b++) begin
      if (be_q[b]) merged_line[b*8 +: 8] = wdata_q[b*8 +: 8];
    end
  end

  // Control FSM: next state, datapath enables and bus outputs.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    write_d      = write_q;
    miss_seen_d  = miss_seen_q;
    victim_d     = victim_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    wb_cnt_d     = wb_cnt_q;
    valid_set_d  = cur_valid;
    dirty_set_d  = cur_dirty;
    plru_set_d   = cur_plru;
    line_we      = 1'b0;
    line_way     = hit_way;
    line_d       = merged_line;
    tag_we       = 1'b0;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state_q)
      S_IDLE: begin
        if (mem_read || mem_write) begin
          addr_d      = mem_address[31:S_OFFSET];
          wdata_d     = mem_wdata256;
          be_d        = mem_byte_enable256;
          write_d     = mem_write;
          miss_seen_d = 1'b0;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        if (hit) begin
          mem_resp   = 1'b1;
          plru_set_d = plru_touch(cur_plru, hit_way);
          if (!miss_seen_q) hit_cnt_d = sat_inc(hit_cnt_q);
          if (write_q) begin
            line_we              = 1'b1;
            line_way             = hit_way;
            line_d               = merged_line;
            dirty_set_d[hit_way] = 1'b1;
          end
          state_d = S_IDLE;
        end else begin
          miss_cnt_d  = sat_inc(miss_cnt_q);
          miss_seen_d = 1'b1;
          victim_d    = victim_sel;
          state_d     = (cur_valid[victim_sel] && cur_dirty[victim_sel]) ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[idx][victim_q], idx, {S_OFFSET{1'b0}}};
        pmem_wdata   = data_q[idx][victim_q];
        if (pmem_resp) begin
          dirty_set_d[victim_q] = 1'b0;
          wb_cnt_d              = sat_inc(wb_cnt_q);
          state_d               = S_FILL;
        end
      end
      S_FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {addr_q, {S_OFFSET{1'b0}}};
        if (pmem_resp) begin
          line_we               = 1'b1;
          line_way              = victim_q;
          line_d                = pmem_rdata;
          tag_we                = 1'b1;
          valid_set_d[victim_q] = 1'b1;
          dirty_set_d[victim_q] = 1'b0;
          state_d               = S_CHECK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers, counters and per-set metadata.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      write_q     <= 1'b0;
      miss_seen_q <= 1'b0;
      victim_q    <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      wb_cnt_q    <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      write_q      <= write_d;
      miss_seen_q  <= miss_seen_d;
      victim_q     <= victim_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      wb_cnt_q     <= wb_cnt_d;
      valid_q[idx] <= valid_set_d;
      dirty_q[idx] <= dirty_set_d;
      plru_q[idx]  <= plru_set_d;
    end
  end

  // Line data and tag arrays; contents survive reset.
  always_ff @(posedge clk) begin
    if (line_we) data_q[idx][line_way] <= line_d;
    if (tag_we)  tag_q[idx][victim_q]  <= tag;
  end

endmodule

// File: tb/tb_cache_nway_wb.sv
// Directed bench for cache_nway_wb: CPU driver task, latency-programmable
// memory responder, one task per scenario with inline checks.
module tb_cache_nway_wb;

  logic         clk;
  logic         rst;
  logic         mem_read, mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata256;
  logic [31:0]  mem_byte_enable256;
  logic [255:0] mem_rdata256;
  logic         mem_resp;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  hit_count, miss_count, wb_count;
  logic [1:0]   state_dbg;

  int           total, bad;
  int           mem_delay, wait_cnt;
  int           pmem_rd_n, pmem_wr_n;
  logic [31:0]  last_rd_addr, last_wr_addr;
  logic [255:0] last_wr_data;

  cache_nway_wb dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata256(mem_wdata256), .mem_byte_enable256(mem_byte_enable256),
    .mem_rdata256(mem_rdata256), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count),
    .state_dbg(state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing-store contents: a distinct pattern per line address.
  function automatic logic [255:0] mem_line(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = a ^ (32'(i) * 32'h1111_1111) ^ 32'hC0DE_0000;
    return l;
  endfunction

  // Memory responder: answers a held request after mem_delay extra cycles.
  initial begin
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (rst && (pmem_read || pmem_write)) begin
        if (wait_cnt >= mem_delay) begin
          pmem_resp = 1'b1;
          wait_cnt = 0;
          if (pmem_write) begin
            pmem_wr_n++;
            last_wr_addr = pmem_address;
            last_wr_data = pmem_wdata;
          end else begin
            pmem_rd_n++;
            last_rd_addr = pmem_address;
            pmem_rdata = mem_line(pmem_address);
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One CPU request, held until mem_resp; returns data and cycles to mem_resp.
  task automatic cpu_req(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [255:0] wd, input logic [31:0] be,
                         output logic [255:0] rdata, output int lat);
    bit done;
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_address = a;
    mem_wdata256 = wd; mem_byte_enable256 = be;
    lat = 0; rdata = '0; done = 0;
    while (!done && lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (mem_resp) begin
        done = 1;
        rdata = mem_rdata256;
      end
    end
    mem_read = 1'b0; mem_write = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL req_timeout addr=%h: no mem_resp after %0d cycles", a, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (mem_resp !== 1'b0) begin bad++; $display("FAIL rst_mem_resp got=%b exp=0", mem_resp); end
    total++; if (pmem_read !== 1'b0) begin bad++; $display("FAIL rst_pmem_read got=%b exp=0", pmem_read); end
    total++; if (pmem_write !== 1'b0) begin bad++; $display("FAIL rst_pmem_write got=%b exp=0", pmem_write); end
    total++; if (pmem_address !== 32'h0) begin bad++; $display("FAIL rst_pmem_address got=%h exp=0", pmem_address); end
    rst = 1'b1;
    #1;
    total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state_dbg); end
    total++; if (hit_count !== 32'd0) begin bad++; $display("FAIL rst_hit_count got=%0d exp=0", hit_count); end
    total++; if (miss_count !== 32'd0) begin bad++; $display("FAIL rst_miss_count got=%0d exp=0", miss_count); end
    total++; if (wb_count !== 32'd0) begin bad++; $display("FAIL rst_wb_count got=%0d exp=0", wb_count); end
  endtask

  task automatic test_cold_read();
    logic [255:0] rd;
    int lat, rd0;
    rd0 = pmem_rd_n;
    cpu_req(1'b1, 1'b0, 32'h0000_1000, '0, '0, rd, lat);
    total++; if (rd !== mem_line(32'h1000)) begin bad++; $display("FAIL cold_rdata got=%h exp=%h", rd, mem_line(32'h1000)); end
    total++; if (lat != mem_delay + 3) begin bad++; $display("FAIL cold_latency got=%0d exp=%0d", lat, mem_delay + 3); end
    total++; if (pmem_rd_n - rd0 != 1) begin bad++; $display("FAIL cold_fill_count got=%0d exp=1", pmem_rd_n - rd0); end
    total++; if (last_rd_addr !== 32'h1000) begin bad++; $display("FAIL cold_fill_addr got=%h exp=00001000", last_rd_addr); end
    total++; if (miss_count !== 32'd1) begin bad++; $display("FAIL cold_miss_count got=%0d exp=1", miss_count); end
    total++; if (hit_count !== 32'd0) begin bad++; $display("FAIL cold_hit_count got=%0d exp=0", hit_count); end
  endtask

  task automatic test_hit();
    logic [255:0] rd;
    int lat, rd0, wr0;
    rd0 = pmem_rd_n; wr0 = pmem_wr_n;
    cpu_req(1'b1, 1'b0, 32'h0000_1000, '0, '0, rd, lat);
    total++; if (lat != 1) begin bad++; $display("FAIL hit_latency got=%0d exp=1", lat); end
    total++; if (rd !== mem_line(32'h1000)) begin bad++; $display("FAIL hit_rdata got=%h exp=%h", rd, mem_line(32'h1000)); end
    total++; if (hit_count !== 32'd1) begin bad++; $display("FAIL hit_count got=%0d exp=1", hit_count); end
    // Byte-offset bits of the address must not matter.
    cpu_req(1'b1, 1'b0, 32'h0000_101C, '0, '0, rd, lat);
    total++; if (lat != 1) begin bad++; $display("FAIL hit_offset_latency got=%0d exp=1", lat); end
    total++; if (hit_count !== 32'd2) begin bad++; $display("FAIL hit_offset_count got=%0d exp=2", hit_count); end
    total++; if ((pmem_rd_n != rd0) || (pmem_wr_n != wr0)) begin
      bad++; $display("FAIL hit_no_pmem got=%0d/%0d exp=%0d/%0d", pmem_rd_n, pmem_wr_n, rd0, wr0);
    end
  endtask

  task automatic test_writeback();
    logic [255:0] rd, wd, exp;
    logic [31:0]  conf [3];
    int lat, wr0;
    conf[0] = 32'h3000; conf[1] = 32'h4000; conf[2] = 32'h5000;
    apply_reset();
    wd = '0; wd[31:0] = 32'hDEAD_BEEF;
    cpu_req(1'b0, 1'b1, 32'h0000_2000, wd, 32'h0000_000F, rd, lat);
    total++; if (rd !== mem_line(32'h2000)) begin bad++; $display("FAIL wr_prewrite_rdata got=%h exp=%h", rd, mem_line(32'h2000)); end
    total++; if ((miss_count !== 32'd1) || (hit_count !== 32'd0)) begin
      bad++; $display("FAIL wr_counts got=miss %0d hit %0d exp=miss 1 hit 0", miss_count, hit_count);
    end
    exp = mem_line(32'h2000);
    exp[31:0] = 32'hDEAD_BEEF;
    cpu_req(1'b1, 1'b0, 32'h0000_2000, '0, '0, rd, lat);
    total++; if (rd !== exp) begin bad++; $display("FAIL wr_readback got=%h exp=%h", rd, exp); end
    total++; if (lat != 1) begin bad++; $display("FAIL wr_readback_latency got=%0d exp=1", lat); end
    wr0 = pmem_wr_n;
    for (int i = 0; i < 3; i++) cpu_req(1'b1, 1'b0, conf[i], '0, '0, rd, lat);
    total++; if ((pmem_wr_n != wr0) || (wb_count !== 32'd0)) begin
      bad++; $display("FAIL wb_early got=%0d writes wb_count %0d exp=0", pmem_wr_n - wr0, wb_count);
    end
    cpu_req(1'b1, 1'b0, 32'h0000_6000, '0, '0, rd, lat);
    total++; if (wb_count !== 32'd1) begin bad++; $display("FAIL wb_count got=%0d exp=1", wb_count); end
    total++; if (last_wr_addr !== 32'h2000) begin bad++; $display("FAIL wb_addr got=%h exp=00002000", last_wr_addr); end
    total++; if (last_wr_data !== exp) begin bad++; $display("FAIL wb_data got=%h exp=%h", last_wr_data, exp); end
    total++; if (lat != 2 * mem_delay + 4) begin bad++; $display("FAIL dirty_miss_latency got=%0d exp=%0d", lat, 2 * mem_delay + 4); end
    total++; if (rd !== mem_line(32'h6000)) begin bad++; $display("FAIL wb_fill_rdata got=%h exp=%h", rd, mem_line(32'h6000)); end
    total++; if ((miss_count !== 32'd5) || (hit_count !== 32'd1)) begin
      bad++; $display("FAIL wb_counts got=miss %0d hit %0d exp=miss 5 hit 1", miss_count, hit_count);
    end
  endtask

  task automatic test_both_rw();
    logic [255:0] rd, wd, exp;
    int lat;
    wd = {8{32'hFFFF_FFFF}};
    wd[63:32] = 32'h1234_5678;
    cpu_req(1'b1, 1'b1, 32'h0000_6000, wd, 32'h0000_00F0, rd, lat);
    total++; if (lat != 1) begin bad++; $display("FAIL rw_latency got=%0d exp=1", lat); end
    total++; if (rd !== mem_line(32'h6000)) begin bad++; $display("FAIL rw_prewrite got=%h exp=%h", rd, mem_line(32'h6000)); end
    exp = mem_line(32'h6000);
    exp[63:32] = 32'h1234_5678;
    cpu_req(1'b1, 1'b0, 32'h0000_6000, '0, '0, rd, lat);
    total++; if (rd !== exp) begin bad++; $display("FAIL rw_as_write got=%h exp=%h", rd, exp); end
  endtask

  task automatic test_plru();
    logic [255:0] rd;
    logic [31:0]  seq [5];
    int lat;
    seq[0] = 32'h1020; seq[1] = 32'h2020; seq[2] = 32'h3020; seq[3] = 32'h4020; seq[4] = 32'h1020;
    apply_reset();
    for (int i = 0; i < 5; i++) cpu_req(1'b1, 1'b0, seq[i], '0, '0, rd, lat);
    total++; if (lat != 1) begin bad++; $display("FAIL plru_hit_a_latency got=%0d exp=1", lat); end
    total++; if ((miss_count !== 32'd4) || (hit_count !== 32'd1)) begin
      bad++; $display("FAIL plru_fill_counts got=miss %0d hit %0d exp=miss 4 hit 1", miss_count, hit_count);
    end
    // A was hit last and D filled last in the right half: tree points at C.
    cpu_req(1'b1, 1'b0, 32'h0000_5020, '0, '0, rd, lat);
    total++; if (miss_count !== 32'd5) begin bad++; $display("FAIL plru_e_miss got=%0d exp=5", miss_count); end
    cpu_req(1'b1, 1'b0, 32'h0000_1020, '0, '0, rd, lat);
    total++; if (lat != 1) begin bad++; $display("FAIL plru_a_kept latency got=%0d exp=1", lat); end
    cpu_req(1'b1, 1'b0, 32'h0000_2020, '0, '0, rd, lat);
    total++; if (lat != 1) begin bad++; $display("FAIL plru_b_kept latency got=%0d exp=1", lat); end
    cpu_req(1'b1, 1'b0, 32'h0000_4020, '0, '0, rd, lat);
    total++; if (lat != 1) begin bad++; $display("FAIL plru_d_kept latency got=%0d exp=1", lat); end
    total++; if (hit_count !== 32'd4) begin bad++; $display("FAIL plru_hits got=%0d exp=4", hit_count); end
    cpu_req(1'b1, 1'b0, 32'h0000_3020, '0, '0, rd, lat);
    total++; if (miss_count !== 32'd6) begin bad++; $display("FAIL plru_c_evicted miss_count got=%0d exp=6", miss_count); end
  endtask

  task automatic test_invalid_first();
    logic [255:0] rd, wd;
    int lat;
    apply_reset();
    wd = {8{32'hA5A5_5A5A}};
    cpu_req(1'b0, 1'b1, 32'h0000_1040, wd, 32'h0000_000F, rd, lat);
    cpu_req(1'b0, 1'b1, 32'h0000_2040, wd, 32'h0000_000F, rd, lat);
    cpu_req(1'b1, 1'b0, 32'h0000_3040, '0, '0, rd, lat);
    cpu_req(1'b1, 1'b0, 32'h0000_4040, '0, '0, rd, lat);
    total++; if (wb_count !== 32'd0) begin bad++; $display("FAIL inv_no_wb got=%0d exp=0", wb_count); end
    // Ways 0..3 hold 1040,2040,3040,4040; tree walk picks way 0 first.
    cpu_req(1'b1, 1'b0, 32'h0000_5040, '0, '0, rd, lat);
    total++; if ((wb_count !== 32'd1) || (last_wr_addr !== 32'h1040)) begin
      bad++; $display("FAIL inv_way0_victim got=wb %0d addr %h exp=wb 1 addr 00001040", wb_count, last_wr_addr);
    end
    cpu_req(1'b1, 1'b0, 32'h0000_6040, '0, '0, rd, lat);
    total++; if (wb_count !== 32'd1) begin bad++; $display("FAIL inv_way2_clean got=%0d exp=1", wb_count); end
    cpu_req(1'b1, 1'b0, 32'h0000_7040, '0, '0, rd, lat);
    total++; if ((wb_count !== 32'd2) || (last_wr_addr !== 32'h2040)) begin
      bad++; $display("FAIL inv_way1_victim got=wb %0d addr %h exp=wb 2 addr 00002040", wb_count, last_wr_addr);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [255:0] rd;
    int lat;
    apply_reset();
    mem_delay = 40;
    @(negedge clk);
    mem_read = 1'b1; mem_address = 32'h0000_1000;
    for (int i = 0; i < 20 && !pmem_read; i++) @(negedge clk);
    total++; if (pmem_read !== 1'b1) begin bad++; $display("FAIL midfill_reach got=%b exp=1", pmem_read); end
    #2;
    rst = 1'b0;
    #1;
    total++; if (pmem_read !== 1'b0) begin bad++; $display("FAIL midfill_pmem_read_drop got=%b exp=0", pmem_read); end
    total++; if (pmem_address !== 32'h0) begin bad++; $display("FAIL midfill_addr got=%h exp=0", pmem_address); end
    mem_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    mem_delay = 1;
    #1;
    total++; if ((miss_count !== 32'd0) || (hit_count !== 32'd0) || (wb_count !== 32'd0)) begin
      bad++; $display("FAIL midfill_counters got=%0d/%0d/%0d exp=0/0/0", hit_count, miss_count, wb_count);
    end
    cpu_req(1'b1, 1'b0, 32'h0000_1000, '0, '0, rd, lat);
    total++; if (lat != mem_delay + 3) begin bad++; $display("FAIL midfill_remiss_latency got=%0d exp=%0d", lat, mem_delay + 3); end
    total++; if ((miss_count !== 32'd1) || (hit_count !== 32'd0)) begin
      bad++; $display("FAIL midfill_remiss_counts got=miss %0d hit %0d exp=miss 1 hit 0", miss_count, hit_count);
    end
    total++; if (rd !== mem_line(32'h1000)) begin bad++; $display("FAIL midfill_rdata got=%h exp=%h", rd, mem_line(32'h1000)); end
  endtask

  initial begin
    total = 0; bad = 0;
    mem_delay = 2;
    pmem_rd_n = 0; pmem_wr_n = 0;
    last_rd_addr = '0; last_wr_addr = '0; last_wr_data = '0;
    rst = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; mem_address = '0;
    mem_wdata256 = '0; mem_byte_enable256 = '0;
    test_reset();
    test_cold_read();
    test_hit();
    test_writeback();
    test_both_rw();
    test_plru();
    test_invalid_first();
    test_reset_mid_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
